// File: rtl/dfa_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : dfa_bit_feeder
//  Description : Serialises WIDTH-bit words into a valid/ready bit stream for
//                a downstream DFA, with back-to-back reload on the last bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module dfa_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last_idx = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_next;
    logic [WIDTH-1:0] w_shreg_shifted;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             w_out_bit;
    logic             w_in_shift;
    logic             w_xfer;
    logic             w_consume;

    // The emitted bit always sits at the output end; shifting moves the next one there.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit       = r_shreg[WIDTH-1];
            assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit       = r_shreg[0];
            assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    assign w_in_shift = (r_state == ST_SHIFT);
    assign bit_valid  = w_in_shift;
    assign busy       = w_in_shift;
    assign bit_out    = w_in_shift & w_out_bit;
    assign last       = w_in_shift && (r_cnt == c_last_idx);
    // Accepting while the last bit drains gives gap-free word-to-word streaming.
    assign in_ready   = !rst && (!w_in_shift || (last && bit_ready));
    assign w_xfer     = in_valid && in_ready;
    assign w_consume  = w_in_shift && bit_ready;

    always_comb begin
        w_state_next = r_state;
        w_shreg_next = r_shreg;
        w_cnt_next   = r_cnt;
        if (w_xfer) begin
            w_state_next = ST_SHIFT;
            w_shreg_next = in_data;
            w_cnt_next   = '0;
        end else if (w_consume) begin
            if (last) begin
                w_state_next = ST_IDLE;
                w_shreg_next = '0;
                w_cnt_next   = '0;
            end else begin
                w_shreg_next = w_shreg_shifted;
                w_cnt_next   = r_cnt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_shreg <= w_shreg_next;
            r_cnt   <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dfa_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dfa_bit_feeder
//  Description : Scoreboard bench driving an MSB-first and an LSB-first feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dfa_bit_feeder;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic b;
        logic l;
    } ebit_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             bit_ready;
    logic             in_ready_m, bit_out_m, bit_valid_m, last_m, busy_m;
    logic             in_ready_l, bit_out_l, bit_valid_l, last_l, busy_l;

    int    checks = 0;
    int    errors = 0;
    ebit_t qm[$];
    ebit_t ql[$];
    logic  m_acc = 1'b0;

    always #5 clk = ~clk;

    dfa_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .bit_out(bit_out_m), .bit_valid(bit_valid_m),
        .bit_ready(bit_ready), .last(last_m), .busy(busy_m)
    );

    dfa_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .bit_out(bit_out_l), .bit_valid(bit_valid_l),
        .bit_ready(bit_ready), .last(last_l), .busy(busy_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a word is simply a list of pending bits in emission order.
    always @(posedge clk) begin
        logic ready_now;
        ready_now = (qm.size() == 0) || (qm.size() == 1 && bit_ready);
        m_acc = 1'b0;
        if (rst) begin
            qm.delete();
            ql.delete();
        end else begin
            if (bit_ready && qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (in_valid && ready_now) begin
                m_acc = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    qm.push_back('{b: in_data[WIDTH-1-i], l: (i == WIDTH-1)});
                    ql.push_back('{b: in_data[i],         l: (i == WIDTH-1)});
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = !rst && ((qm.size() == 0) || (qm.size() == 1 && bit_ready));
        chk("in_ready_msb", in_ready_m, exp_rdy);
        chk("in_ready_lsb", in_ready_l, exp_rdy);
        chk("bit_valid_msb", bit_valid_m, qm.size() != 0);
        chk("bit_valid_lsb", bit_valid_l, ql.size() != 0);
        chk("busy_msb", busy_m, qm.size() != 0);
        chk("busy_lsb", busy_l, ql.size() != 0);
        if (qm.size() != 0) begin
            chk("bit_out_msb", bit_out_m, qm[0].b);
            chk("last_msb", last_m, qm[0].l);
            chk("bit_out_lsb", bit_out_l, ql[0].b);
            chk("last_lsb", last_l, ql[0].l);
        end else begin
            chk("idle_bit_out_msb", bit_out_m, 0);
            chk("idle_last_msb", last_m, 0);
            chk("idle_bit_out_lsb", bit_out_l, 0);
            chk("idle_last_lsb", last_l, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 200);
        if (!m_acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_size(input int sz);
        int n;
        n = 0;
        while (qm.size() != sz && n < 200) begin
            tick();
            n++;
        end
        chk("wait_pending_bits", qm.size(), sz);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        bit_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Plain word, then two words held back to back
        send(8'hB4);
        wait_size(0);
        send(8'hB4);
        send(8'h0F);
        wait_size(0);

        // Stall while bit index 2 is on the output
        send(8'hB4);
        wait_size(WIDTH - 2);
        bit_ready = 1'b0;
        repeat (3) tick();
        bit_ready = 1'b1;
        wait_size(0);

        // Reset mid-word, then a fresh word
        send(8'hB4);
        wait_size(WIDTH - 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(8'h80);
        wait_size(0);

        // Offer a word mid-stream: must be ignored
        send(8'hB4);
        wait_size(WIDTH - 4);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_valid = 1'b0;
        wait_size(0);

        // Random traffic with back-pressure, producer holding until accepted
        for (int c = 0; c < 4000; c++) begin
            bit_ready = ($urandom % 4) != 0;
            rst       = ($urandom % 250) == 0;
            if (!(in_valid && !m_acc)) begin
                if (($urandom % 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = WIDTH'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
        end

        rst       = 1'b0;
        in_valid  = 1'b0;
        bit_ready = 1'b1;
        wait_size(0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
